// File: rtl/inv_chk_pkg.sv
// Shared types and defaults for the inverter response checker.
package inv_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    WAIT,
    DONE
  } state_t;

  localparam int unsigned DEF_SETTLE_CYCLES  = 2;
  localparam int unsigned DEF_EXPECT_TOGGLES = 13;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;
  localparam int unsigned DEF_CNT_W          = 8;

endpackage

// File: rtl/inv_response_checker_stim_edge_det.sv
// Previous-value register and combinational toggle detect for stim_in.
module stim_edge_det (
  input  logic clk,
  input  logic stim_in,
  output logic edge_c
);

  logic prev_stim;

  // Loads every cycle, reset included, so there is never a false edge out of reset.
  always_ff @(posedge clk) begin
    prev_stim <= stim_in;
  end

  assign edge_c = stim_in ^ prev_stim;

endmodule

// File: rtl/inv_response_checker.sv
// Response-side checker: after each stimulus edge waits a settle window, then checks dut_out == ~stim_in.
module inv_response_checker
  import inv_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned EXPECT_TOGGLES = DEF_EXPECT_TOGGLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stim_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             mismatch,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  // The edge cycle itself counts toward the window, so SAMPLE lands SETTLE_CYCLES after the edge.
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [WW-1:0]    WAIT_LAST   = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TOG_TARGET  = CNT_W'(EXPECT_TOGGLES);

  state_t           state, state_n;
  logic [SW-1:0]    settle_ctr, settle_n;
  logic [WW-1:0]    wait_ctr, wait_n;
  logic [CNT_W-1:0] toggle_n, err_n, toggle_inc, err_inc;
  logic             timeout_n, pass_n, mismatch_n, busy_n, done_n;
  logic             stim_edge, sample_bad;

  stim_edge_det u_edge (
    .clk     (clk),
    .stim_in (stim_in),
    .edge_c  (stim_edge)
  );

  assign sample_bad = (dut_out == stim_in);
  assign toggle_inc = (toggle_cnt == CNT_MAX) ? toggle_cnt : toggle_cnt + CNT_W'(1);
  assign err_inc    = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CNT_W'(1);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_ctr <= '0;
      wait_ctr   <= '0;
      toggle_cnt <= '0;
      err_cnt    <= '0;
      timeout    <= 1'b0;
      pass       <= 1'b0;
      mismatch   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      settle_ctr <= settle_n;
      wait_ctr   <= wait_n;
      toggle_cnt <= toggle_n;
      err_cnt    <= err_n;
      timeout    <= timeout_n;
      pass       <= pass_n;
      mismatch   <= mismatch_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  // Next-state, counters and output decode.
  always_comb begin
    state_n    = state;
    settle_n   = settle_ctr;
    wait_n     = wait_ctr;
    toggle_n   = toggle_cnt;
    err_n      = err_cnt;
    timeout_n  = timeout;
    pass_n     = pass;
    mismatch_n = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n   = SETTLE;
          settle_n  = SETTLE_LOAD;
          toggle_n  = '0;
          err_n     = '0;
          timeout_n = 1'b0;
          pass_n    = 1'b0;
        end
      end
      SETTLE: begin
        if (stim_edge) begin
          toggle_n = toggle_inc;
          settle_n = SETTLE_LOAD;
        end else if (settle_ctr <= SW'(1)) begin
          state_n = SAMPLE;
        end else begin
          settle_n = settle_ctr - SW'(1);
        end
      end
      SAMPLE: begin
        if (sample_bad) begin
          mismatch_n = 1'b1;
          err_n      = err_inc;
        end
        if (stim_edge) begin
          toggle_n = toggle_inc;
          settle_n = SETTLE_LOAD;
          state_n  = SETTLE;
        end else if (toggle_cnt == TOG_TARGET) begin
          state_n = DONE;
          pass_n  = (err_n == '0) && !timeout && (toggle_cnt == TOG_TARGET);
        end else begin
          state_n = WAIT;
          wait_n  = '0;
        end
      end
      WAIT: begin
        if (stim_edge) begin
          toggle_n = toggle_inc;
          settle_n = SETTLE_LOAD;
          state_n  = SETTLE;
        end else if (wait_ctr == WAIT_LAST) begin
          timeout_n = 1'b1;
          pass_n    = 1'b0;
          state_n   = DONE;
        end else begin
          wait_n = wait_ctr + WW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == SETTLE) || (state_n == SAMPLE) || (state_n == WAIT);
    done_n = (state_n == DONE);
  end

endmodule
